// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scrub controller: FSM state encoding and
// the all-ones fill used by the saturating error counters.
package ecc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_HOST_RD   = 3'd1;
    localparam state_t ST_SCRUB_RD  = 3'd2;
    localparam state_t ST_SCRUB_CHK = 3'd3;
    localparam state_t ST_SCRUB_WB  = 3'd4;

    // Counters are sliced from this, so counter widths are limited to 32 bits.
    localparam int                       SAT_MAX_WIDTH = 32;
    localparam logic [SAT_MAX_WIDTH-1:0] SAT_ALL_ONES  = '1;

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module ecc_sat_counter
    import ecc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = SAT_ALL_ONES[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Host/scrub arbiter in front of a SECDED RAM with saturating error counters.
// Background scrubbing is built only when ECC_SCRUB_EN is defined.
//
// state        | meaning
// IDLE         | accepting host requests, scrub timer running
// HOST_RD      | host read data arriving from the RAM, captured for the host
// SCRUB_RD     | read of scrub_ptr issued
// SCRUB_CHK    | scrub read result evaluated for sbe/dbe
// SCRUB_WB     | corrected word written back to scrub_ptr
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_sbe,
    output logic                  host_dbe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_sbe,
    input  logic                  ram_dbe,
    output logic [CNT_WIDTH-1:0]  sbe_count,
    output logic [CNT_WIDTH-1:0]  dbe_count,
    output logic [ADDR_WIDTH-1:0] dbe_addr,
    output logic                  scrub_wrap
);

    if (SCRUB_INTERVAL < 2) begin : g_interval_check
        $error("SCRUB_INTERVAL must be at least 2");
    end

    state_t                state_q, state_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  sbe_q, sbe_d;
    logic                  dbe_q, dbe_d;
    logic [ADDR_WIDTH-1:0] dbe_addr_q, dbe_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  host_xfer;
    logic                  sbe_inc, dbe_inc;

`ifdef ECC_SCRUB_EN
    localparam int TMR_W = $clog2(SCRUB_INTERVAL);
    localparam logic [TMR_W-1:0] TMR_DUE = TMR_W'(SCRUB_INTERVAL - 1);

    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  wrap_q, wrap_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
`endif

    assign host_ready = (state_q == ST_IDLE) && !rst;
    assign host_xfer  = host_req && host_ready;

    always_comb begin
        state_d    = state_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        sbe_d      = sbe_q;
        dbe_d      = dbe_q;
        dbe_addr_d = dbe_addr_q;
        rd_addr_d  = rd_addr_q;
        sbe_inc    = 1'b0;
        dbe_inc    = 1'b0;
        ram_addr   = host_addr;
        ram_din    = host_wdata;
        ram_we     = 1'b0;
`ifdef ECC_SCRUB_EN
        timer_d    = timer_q;
        ptr_d      = ptr_q;
        wrap_d     = 1'b0;
        wb_data_d  = wb_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (host_xfer) begin
                    ram_we    = host_we;
                    rd_addr_d = host_addr;
                    if (!host_we) begin
                        state_d = ST_HOST_RD;
                    end
                end
`ifdef ECC_SCRUB_EN
                // A due scrub waits here until the host leaves a gap.
                else if (timer_q == TMR_DUE) begin
                    timer_d = '0;
                    state_d = ST_SCRUB_RD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            ST_HOST_RD: begin
                rvalid_d = 1'b1;
                rdata_d  = ram_dout;
                sbe_d    = ram_sbe;
                dbe_d    = ram_dbe;
                sbe_inc  = ram_sbe;
                dbe_inc  = ram_dbe;
                if (ram_dbe) begin
                    dbe_addr_d = rd_addr_q;
                end
                state_d = ST_IDLE;
            end
`ifdef ECC_SCRUB_EN
            ST_SCRUB_RD: begin
                ram_addr = ptr_q;
                state_d  = ST_SCRUB_CHK;
            end
            ST_SCRUB_CHK: begin
                ram_addr  = ptr_q;
                sbe_inc   = ram_sbe;
                dbe_inc   = ram_dbe;
                wb_data_d = ram_dout;
                if (ram_dbe) begin
                    dbe_addr_d = ptr_q;
                end
                // An uncorrectable word is never written back.
                if (ram_sbe && !ram_dbe) begin
                    state_d = ST_SCRUB_WB;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    wrap_d  = (ptr_q == '1);
                    state_d = ST_IDLE;
                end
            end
            ST_SCRUB_WB: begin
                ram_addr = ptr_q;
                ram_din  = wb_data_q;
                ram_we   = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                wrap_d   = (ptr_q == '1);
                state_d  = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            sbe_q      <= 1'b0;
            dbe_q      <= 1'b0;
            dbe_addr_q <= '0;
            rd_addr_q  <= '0;
`ifdef ECC_SCRUB_EN
            timer_q    <= '0;
            ptr_q      <= '0;
            wrap_q     <= 1'b0;
            wb_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            sbe_q      <= sbe_d;
            dbe_q      <= dbe_d;
            dbe_addr_q <= dbe_addr_d;
            rd_addr_q  <= rd_addr_d;
`ifdef ECC_SCRUB_EN
            timer_q    <= timer_d;
            ptr_q      <= ptr_d;
            wrap_q     <= wrap_d;
            wb_data_q  <= wb_data_d;
`endif
        end
    end

    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_sbe_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sbe_inc),
        .count (sbe_count)
    );

    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_dbe_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (dbe_inc),
        .count (dbe_count)
    );

    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign host_sbe    = sbe_q;
    assign host_dbe    = dbe_q;
    assign dbe_addr    = dbe_addr_q;
`ifdef ECC_SCRUB_EN
    assign scrub_wrap  = wrap_q;
`else
    assign scrub_wrap  = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural SECDED RAM model.
// Scrub scenarios run only when ECC_SCRUB_EN is defined for the build.
module tb_ecc_scrub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_req, host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ready, host_rvalid, host_sbe, host_dbe;
    logic [7:0] host_rdata;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [7:0] ram_dout;
    logic       ram_sbe, ram_dbe;
    logic [1:0] sbe_count, dbe_count;
    logic [3:0] dbe_addr;
    logic       scrub_wrap;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [16];
    logic       sbe_at [16];
    logic       dbe_at [16];
    int         wr_count = 0;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .SCRUB_INTERVAL(8), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_sbe(host_sbe), .host_dbe(host_dbe),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .ram_sbe(ram_sbe), .ram_dbe(ram_dbe),
        .sbe_count(sbe_count), .dbe_count(dbe_count), .dbe_addr(dbe_addr),
        .scrub_wrap(scrub_wrap)
    );

    // RAM model: contents 0x10+addr after reset, registered read, injected error flags.
    always @(posedge clk) begin
        if (ram_we) wr_count <= wr_count + 1;
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
        ram_sbe  <= sbe_at[ram_addr];
        ram_dbe  <= dbe_at[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    32'(host_ready),  0);
        check({tag, "_rvalid"},   32'(host_rvalid), 0);
        check({tag, "_rdata"},    32'(host_rdata),  0);
        check({tag, "_sbe"},      32'(host_sbe),    0);
        check({tag, "_dbe"},      32'(host_dbe),    0);
        check({tag, "_sbe_cnt"},  32'(sbe_count),   0);
        check({tag, "_dbe_cnt"},  32'(dbe_count),   0);
        check({tag, "_dbe_addr"}, 32'(dbe_addr),    0);
        check({tag, "_wrap"},     32'(scrub_wrap),  0);
        check({tag, "_ram_we"},   32'(ram_we),      0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!host_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(host_ready), 1);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d, input string tag);
        wait_ready(tag);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        check({tag, "_ram_we"},  32'(ram_we),   1);
        check({tag, "_ram_din"}, 32'(ram_din),  32'(d));
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, input logic inj_sbe, input logic inj_dbe,
                             input logic [7:0] exp_d, input string tag);
        wait_ready(tag);
        sbe_at[a] = inj_sbe;
        dbe_at[a] = inj_dbe;
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        #1;
        check({tag, "_rd_we"}, 32'(ram_we), 0);
        @(negedge clk);
        host_req  = 1'b0;
        sbe_at[a] = 1'b0;
        dbe_at[a] = 1'b0;
        check({tag, "_rvalid_t1"}, 32'(host_rvalid), 0);
        @(negedge clk);
        check({tag, "_rvalid_t2"}, 32'(host_rvalid), 1);
        check({tag, "_rdata"},     32'(host_rdata),  32'(exp_d));
        check({tag, "_sbe"},       32'(host_sbe),    32'(inj_sbe));
        check({tag, "_dbe"},       32'(host_dbe),    32'(inj_dbe));
        @(negedge clk);
        check({tag, "_rvalid_t3"}, 32'(host_rvalid), 0);
    endtask

    initial begin
        int n;
        int base;
        int wraps;
        int low_ready;
        logic [1:0] exp_cnt;
        for (int i = 0; i < 16; i++) begin
            sbe_at[i] = 1'b0;
            dbe_at[i] = 1'b0;
        end
        rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        host_write(4'd3, 8'hA5, "wr_a5");
        host_read(4'd3, 1'b0, 1'b0, 8'hA5, "rd_a5");
        host_read(4'd7, 1'b1, 1'b0, 8'h17, "rd_sbe");
        check("rd_sbe_count", 32'(sbe_count), 1);
        check("rd_sbe_dbecnt", 32'(dbe_count), 0);
        host_read(4'd2, 1'b0, 1'b1, 8'h12, "rd_dbe");
        check("rd_dbe_count", 32'(dbe_count), 1);
        check("rd_dbe_addr", 32'(dbe_addr), 2);
        check("rd_dbe_sbecnt", 32'(sbe_count), 1);

        // sbe_count 1 -> 2 -> 3 -> stays 3
        for (int k = 0; k < 3; k++) begin
            host_read(4'd7, 1'b1, 1'b0, 8'h17, "rd_sat");
            exp_cnt = (k == 0) ? 2'd2 : 2'd3;
            check("sat_sbe_count", 32'(sbe_count), 32'(exp_cnt));
        end

`ifndef ECC_SCRUB_EN
        wraps = 0; low_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (scrub_wrap) wraps++;
            if (!host_ready || ram_we) low_ready++;
        end
        check("noscrub_wrap", 32'(wraps), 0);
        check("noscrub_idle", 32'(low_ready), 0);
        host_read(4'd6, 1'b0, 1'b1, 8'h16, "rd_dbe6");
        check("rd_dbe6_addr", 32'(dbe_addr), 6);
        check("rd_dbe6_count", 32'(dbe_count), 2);
`else
        // Reset in SCRUB_CHK with sbe pending: no write-back, clean outputs.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sbe_at[0] = 1'b1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_scrub_rd_addr", 32'(ram_addr), 0);
        check("abort_scrub_rd_ready", 32'(host_ready), 0);
        @(negedge clk);
        check("abort_chk_ready", 32'(host_ready), 0);
        base = wr_count;
        rst = 1'b1;
        #1;
        check("abort_chk_ram_we", 32'(ram_we), 0);
        @(negedge clk);
        check_reset_outputs("abort");
        @(negedge clk);
        check("abort_no_wb", 32'(wr_count), 32'(base));
        sbe_at[0] = 1'b0;

        // Host held high while the scrub is due: host first, scrub right after.
        rst = 1'b0;
        repeat (7) @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd4; host_wdata = 8'h5A;
        #1;
        check("prio_due_ready", 32'(host_ready), 1);
        check("prio_due_we", 32'(ram_we), 1);
        @(negedge clk);
        check("prio_hold_ready", 32'(host_ready), 1);
        check("prio_hold_we", 32'(ram_we), 1);
        host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        check("prio_gap_ready", 32'(host_ready), 1);
        @(negedge clk);
        check("prio_scrub_ready", 32'(host_ready), 0);
        check("prio_scrub_addr", 32'(ram_addr), 0);

        // Single-bit error at addr 5 found by scrub gets written back.
        sbe_at[5] = 1'b1;
        n = 0;
        while (!ram_we && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wb_seen", 32'(ram_we), 1);
        check("wb_addr", 32'(ram_addr), 5);
        check("wb_data", 32'(ram_din), 32'h15);
        check("wb_sbe_count", 32'(sbe_count), 1);
        check("wb_ready", 32'(host_ready), 0);
        sbe_at[5] = 1'b0;

        // Double-bit error at addr 9: address latched, no write.
        base = wr_count;
        dbe_at[9] = 1'b1;
        n = 0;
        while (dbe_count != 2'd1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("dbe_count", 32'(dbe_count), 1);
        check("dbe_addr", 32'(dbe_addr), 9);
        repeat (2) @(negedge clk);
        check("dbe_no_wb", 32'(wr_count), 32'(base));
        check("dbe_sbe_count", 32'(sbe_count), 1);
        dbe_at[9] = 1'b0;

        // 16 scrubs of 10 cycles each from reset; 17th read must be addr 0.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wraps = 0;
        for (int i = 1; i <= 168; i++) begin
            @(negedge clk);
            if (scrub_wrap) wraps++;
        end
        check("wrap_pulses", 32'(wraps), 1);
        check("wrap_ptr_zero", 32'(ram_addr), 0);
        check("wrap_scrub_ready", 32'(host_ready), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 4, RAM address width; DATA_WIDTH, default 8, data width; SCRUB_INTERVAL, default 64, idle cycles between scrub accesses; CNT_WIDTH, default 16, error counter width.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: host_req  in  1  host access request.
REQ-005 SHALL have ports: host_we  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports: host_addr  in  ADDR_WIDTH  host address.
REQ-007 SHALL have ports: host_wdata  in  DATA_WIDTH  host write data.
REQ-008 SHALL have ports: host_ready  out  1  controller accepts the request this cycle.
REQ-009 SHALL have ports: host_rvalid  out  1  one-cycle read-data strobe.
REQ-010 SHALL have ports: host_rdata, host_sbe, host_dbe  out  DATA_WIDTH/1/1  read data and its error flags.
REQ-011 SHALL have ports: ram_addr, ram_din, ram_we  out  ADDR_WIDTH/DATA_WIDTH/1  to the SECDED RAM.
REQ-012 SHALL have ports: ram_dout, ram_sbe, ram_dbe  in  DATA_WIDTH/1/1  registered RAM read results, valid one cycle after a read is issued.
REQ-013 SHALL have ports: sbe_count, dbe_count  out  CNT_WIDTH  saturating error counters; dbe_addr  out  ADDR_WIDTH  last double-error address; scrub_wrap  out  1  full-pass pulse.

Function
REQ-014 SHALL implement FSM states IDLE, HOST_RD, SCRUB_RD, SCRUB_CHK, SCRUB_WB.
REQ-015 SHALL drive host_ready = 1 only in IDLE and never during reset; a transfer is host_req && host_ready.
REQ-016 SHALL issue a host write in the cycle of transfer (ram_we = 1) and remain in IDLE.
REQ-017 SHALL issue a host read in the cycle of transfer and enter HOST_RD; in HOST_RD it captures the RAM outputs, so host_rvalid pulses exactly 2 cycles after transfer together with host_rdata/host_sbe/host_dbe, then returns to IDLE.
REQ-018 SHALL count cycles spent in IDLE without a transfer in a scrub timer; when the timer reaches SCRUB_INTERVAL-1 and host_req = 0, it enters SCRUB_RD and clears the timer.
REQ-019 SHALL give host requests strict priority: host_req = 1 in IDLE always wins over a due scrub, which stays pending.
REQ-020 SHALL issue a read of scrub_ptr in SCRUB_RD and enter SCRUB_CHK; in SCRUB_CHK it evaluates ram_sbe/ram_dbe.
REQ-021 SHALL on ram_sbe in SCRUB_CHK enter SCRUB_WB and write ram_dout back to scrub_ptr (one cycle); otherwise it returns to IDLE.
REQ-022 SHALL on ram_dbe in SCRUB_CHK latch dbe_addr = scrub_ptr and perform no write-back.
REQ-023 SHALL increment scrub_ptr modulo 2^ADDR_WIDTH on leaving SCRUB_CHK/SCRUB_WB and pulse scrub_wrap for one cycle on the wrap to 0.
REQ-024 SHALL increment sbe_count/dbe_count on every sbe/dbe from host reads or scrub reads; counters saturate at all-ones.
REQ-025 SHALL hold ram_we = 0 in all states other than the write cycles of REQ-016 and REQ-021; ram_din/ram_addr are don't-care when not used.

Reset
REQ-026 SHALL on rst force state IDLE, host_ready = 0, host_rvalid = 0, host_rdata = 0, host_sbe = host_dbe = 0, counters = 0, dbe_addr = 0, scrub_ptr = 0, timer = 0, scrub_wrap = 0, ram_we = 0.
REQ-027 SHALL abandon any in-flight read or scrub on reset mid-operation: no rvalid and no write-back is issued.

Configuration
REQ-028 SHALL, with ECC_SCRUB_EN defined, include the scrub timer, scrub_ptr, SCRUB_RD/SCRUB_CHK/SCRUB_WB and scrub_wrap.
REQ-029 SHALL, without ECC_SCRUB_EN, omit the scrub logic, tie scrub_wrap = 0 and dbe_addr = last host double-error address, and keep host paths and counters unchanged.

Structure
REQ-030 SHALL take the FSM state enum and the counter-saturation constant from the shared package ecc_pkg.
REQ-031 SHALL use one sub-module, ecc_sat_counter (saturating counter), instantiated twice.

Verification
REQ-032 SHALL test: write 0xA5 to addr 3, read addr 3 -> host_rvalid 2 cycles after transfer, rdata 0xA5, sbe = dbe = 0.
REQ-033 SHALL test: model RAM returns sbe at addr 5 during scrub -> write-back of ram_dout to addr 5 in SCRUB_WB, sbe_count = 1.
REQ-034 SHALL test: model RAM returns dbe at addr 9 during scrub -> no ram_we, dbe_addr = 9, dbe_count = 1.
REQ-035 SHALL test: host_req held high when the scrub timer is due -> host served first, scrub runs on the first idle cycle after.
REQ-036 SHALL test: 16 scrubs with ADDR_WIDTH = 4 -> scrub_wrap pulses once and scrub_ptr = 0.
REQ-037 SHALL test: rst asserted in SCRUB_CHK with sbe pending -> no write-back, and all outputs match REQ-026 the next cycle.
